sram_arbiter: RTL and testbench

- Shares one 16x8 synchronous scratch SRAM between two requesters: port C (CPU load/store path) and port D (debug/loader path that preloads or inspects memory).
- A 3-state FSM serialises accesses; ties are broken round-robin.
- Each access is a fixed 3-cycle transaction with a one-cycle done pulse.
- A saturating counter records arbitration conflicts for debug.

---
 rtl/sram_arbiter.sv | 118 +++++++++++
 tb/tb_sram_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: two requesters (C = CPU path, D = debug/loader path) share a
// 16x8 synchronous scratch SRAM. A 3-state FSM serialises fixed 3-cycle
// transactions, breaks ties round-robin and counts arbitration conflicts.
module sram_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_done,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              busy,
  output logic              last_grant,
  output logic [CNT_W-1:0]  conflict_cnt
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Transaction latched at grant; later requester input changes are ignored.
  logic              win_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic any_req;
  logic both_req;
  logic win;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Arbitration decision: sole requester wins, a tie goes opposite to last_grant.
  always_comb begin
    any_req  = c_req | d_req;
    both_req = c_req & d_req;
    win      = both_req ? ~last_grant : d_req;
  end

  // Capture the winner's command when a grant is issued.
  always_ff @(posedge CLK) begin
    if (state == IDLE && any_req) begin
      win_q   <= win;
      we_q    <= win ? d_we    : c_we;
      addr_q  <= win ? d_addr  : c_addr;
      wdata_q <= win ? d_wdata : c_wdata;
    end
  end

  // Memory write; reset forces IDLE asynchronously, so an aborted ACCESS never writes.
  always_ff @(posedge CLK) begin
    if (state == ACCESS && we_q) mem[addr_q] <= wdata_q;
  end

  // Control FSM with registered handshake, read data and conflict counter.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= IDLE;
      c_gnt        <= 1'b0;
      d_gnt        <= 1'b0;
      c_done       <= 1'b0;
      d_done       <= 1'b0;
      c_rdata      <= '0;
      d_rdata      <= '0;
      busy         <= 1'b0;
      last_grant   <= 1'b1;
      conflict_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (both_req) conflict_cnt <= sat_inc(conflict_cnt);
          if (any_req) begin
            c_gnt      <= ~win;
            d_gnt      <= win;
            last_grant <= win;
            busy       <= 1'b1;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (!we_q) begin
            if (win_q) d_rdata <= mem[addr_q];
            else       c_rdata <= mem[addr_q];
          end
          c_gnt  <= 1'b0;
          d_gnt  <= 1'b0;
          c_done <= ~win_q;
          d_done <= win_q;
          state  <= DONE;
        end
        DONE: begin
          c_done <= 1'b0;
          d_done <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed stimulus with a done-driven scoreboard for sram_arbiter.
module tb_sram_arbiter;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       c_req = 0, c_we = 0, d_req = 0, d_we = 0;
  logic [3:0] c_addr = 0, d_addr = 0;
  logic [7:0] c_wdata = 0, d_wdata = 0;
  logic       c_gnt, c_done, d_gnt, d_done, busy, last_grant;
  logic [7:0] c_rdata, d_rdata, conflict_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_done_cyc = 0;

  typedef struct {
    bit         port;   // 0 = C, 1 = D
    bit         rd;
    logic [7:0] data;
    int         gap;    // required cycles since previous done, 0 = unchecked
  } exp_t;
  exp_t q[$];

  sram_arbiter #(.ADDR_W(4), .DATA_W(8), .CNT_W(8)) dut (
    .CLK(CLK), .RESET(RESET),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_done(c_done), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .busy(busy), .last_grant(last_grant), .conflict_cnt(conflict_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push(input bit port, input bit rd, input logic [7:0] data, input int gap);
    exp_t e;
    e.port = port; e.rd = rd; e.data = data; e.gap = gap;
    q.push_back(e);
  endfunction

  // Monitor: every done pulse pops one expected transaction.
  always @(negedge CLK) begin
    exp_t e;
    cyc++;
    if (c_done || d_done) begin
      if (c_done && d_done) chk("both_done", 1, 0);
      if (q.size() == 0) begin
        chk("unexpected_done", {c_done, d_done}, 0);
      end else begin
        e = q.pop_front();
        chk("done_port", d_done, e.port);
        if (e.rd) chk(e.port ? "d_rdata" : "c_rdata", e.port ? d_rdata : c_rdata, e.data);
        if (e.gap != 0) chk("done_gap", cyc - last_done_cyc, e.gap);
        last_done_cyc = cyc;
      end
    end
  end

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    c_req = 0; d_req = 0;
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  // Requester: holds req for n back-to-back transactions, drops it after the last done.
  task automatic drive(input bit port, input int n, input bit we, input logic [3:0] a, input logic [7:0] wd);
    int got = 0;
    int t;
    @(negedge CLK);
    if (port) begin d_we = we; d_addr = a; d_wdata = wd; d_req = 1; end
    else      begin c_we = we; c_addr = a; c_wdata = wd; c_req = 1; end
    while (got < n) begin
      t = 0;
      do begin
        @(negedge CLK);
        t++;
      end while (!(port ? d_done : c_done) && t < 20);
      if (!(port ? d_done : c_done)) begin
        chk(port ? "d_done_timeout" : "c_done_timeout", 0, 1);
        break;
      end
      got++;
    end
    if (port) d_req = 0; else c_req = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("rst_c_gnt", c_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_done", {c_done, d_done}, 0);
    chk("rst_c_rdata", c_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_last_grant", last_grant, 1);
    chk("rst_cnt", conflict_cnt, 0);

    // Test 1: timed C write 0xA5 @3, then read it back.
    push(0, 0, 8'h00, 0);
    @(negedge CLK);
    c_we = 1; c_addr = 3; c_wdata = 8'hA5; c_req = 1;
    @(negedge CLK);
    chk("t1_gnt", c_gnt, 1);
    chk("t1_busy", busy, 1);
    chk("t1_done_early", c_done, 0);
    @(negedge CLK);
    chk("t1_gnt_off", c_gnt, 0);
    chk("t1_done", c_done, 1);
    c_req = 0;
    @(negedge CLK);
    chk("t1_done_pulse", c_done, 0);
    chk("t1_idle", busy, 0);
    push(0, 1, 8'hA5, 0);
    drive(0, 1, 0, 3, 8'h00);
    chk("t1_d_rdata", d_rdata, 0);
    chk("t1_last_grant", last_grant, 0);

    // Test 2: simultaneous writes to @5 right after reset, C wins, D read sees D's data.
    do_reset();
    push(0, 0, 0, 0);
    push(1, 0, 0, 3);
    fork
      drive(0, 1, 1, 5, 8'h11);
      drive(1, 1, 1, 5, 8'h22);
    join
    push(1, 1, 8'h22, 0);
    drive(1, 1, 0, 5, 8'h00);
    chk("t2_last_grant", last_grant, 1);
    chk("t2_cnt", conflict_cnt, 1);

    // Test 3: six back-to-back transactions alternate C,D and finish 3 cycles apart.
    do_reset();
    for (int i = 0; i < 6; i++) push(i[0], 0, 0, (i == 0) ? 0 : 3);
    fork
      drive(0, 3, 1, 8, 8'h10);
      drive(1, 3, 1, 9, 8'h20);
    join
    chk("t3_cnt", conflict_cnt, 5);
    chk("t3_last_grant", last_grant, 1);

    // Test 4: top and bottom addresses are distinct.
    push(1, 0, 0, 0);
    drive(1, 1, 1, 15, 8'h7E);
    push(1, 0, 0, 0);
    drive(1, 1, 1, 0, 8'h00);
    push(0, 1, 8'h7E, 0);
    drive(0, 1, 0, 15, 8'h00);
    push(0, 1, 8'h00, 0);
    drive(0, 1, 0, 0, 8'h00);
    chk("t4_d_rdata_held", d_rdata, 8'h22 & 8'h00);

    // Test 5: reset during the ACCESS of a D write aborts it.
    do_reset();
    push(1, 0, 0, 0);
    drive(1, 1, 1, 2, 8'h44);
    @(negedge CLK);
    d_we = 1; d_addr = 2; d_wdata = 8'h99; d_req = 1;
    @(negedge CLK);
    chk("t5_gnt", d_gnt, 1);
    #2 RESET = 1'b1;
    #1;
    chk("t5_gnt_async", d_gnt, 0);
    chk("t5_busy_async", busy, 0);
    d_req = 0;
    @(negedge CLK);
    RESET = 1'b0;
    chk("t5_last_grant", last_grant, 1);
    chk("t5_cnt", conflict_cnt, 0);
    push(1, 1, 8'h44, 0);
    drive(1, 1, 0, 2, 8'h00);

    // Test 6: 299 conflicting arbitrations saturate the counter.
    do_reset();
    for (int i = 0; i < 300; i++) push(i[0], 0, 0, (i == 0) ? 0 : 3);
    fork
      drive(0, 150, 1, 10, 8'h5A);
      drive(1, 150, 1, 11, 8'hC3);
    join
    chk("t6_cnt_sat", conflict_cnt, 8'hFF);

    repeat (3) @(negedge CLK);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
